// File: rtl/seq_mac.sv
// Sequential shift-and-add multiply-accumulate engine for one dot product.
// Operand pairs arrive on a valid/ready handshake, each is multiplied over
// WIDTH cycles, the product is accumulated, and the finished sum is offered
// downstream on a second valid/ready handshake. All adders are ripple-carry
// chains of fulladder cells.

// One-bit full adder cell.
module fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// N-bit ripple-carry adder built from fulladder cells, carry-in tied low.
module ripple_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fulladder u_fa (
            .x   (x[i]),
            .y   (y[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[N];
endmodule

module seq_mac #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_overflow
);
    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t                 state;
    logic [WIDTH-1:0]       a_lat;
    logic [WIDTH-1:0]       b_lat;
    logic                   last_lat;
    logic [CNT_W-1:0]       count;
    logic [2*WIDTH-1:0]     product;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   overflow;

    logic [2*WIDTH-1:0]     partial;
    logic [2*WIDTH-1:0]     prod_next;
    logic                   prod_carry;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   acc_carry;

    // Shifted multiplicand for the current multiplier bit, or zero if that bit is clear.
    always_comb begin
        // NOTE: default first so every path assigns partial and no latch is inferred.
        partial = '0;
        if (b_lat[count]) begin
            partial = {{WIDTH{1'b0}}, a_lat} << count;
        end
    end

    ripple_add #(.N(2*WIDTH)) u_prod_add (
        .x   (product),
        .y   (partial),
        .sum (prod_next),
        .cout(prod_carry)
    );

    ripple_add #(.N(ACC_WIDTH)) u_acc_add (
        .x   (acc),
        .y   (ACC_WIDTH'(product)),
        .sum (acc_next),
        .cout(acc_carry)
    );

    // The running product never exceeds (2^WIDTH-1)^2, so its adder cannot carry out.
    assert property (@(posedge clk) disable iff (rst) (state != MUL) || !prod_carry);

    assign out_sum      = acc;
    assign out_overflow = overflow;

    // Control FSM with registered handshake outputs and the datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so an aborted operation leaves no residue.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            last_lat  <= 1'b0;
            count     <= '0;
            product   <= '0;
            acc       <= '0;
            overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_lat    <= a;
                        b_lat    <= b;
                        last_lat <= in_last;
                        product  <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    product <= prod_next;
                    if (count == LAST_CNT) begin
                        state <= ACC;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (acc_carry) begin
                        overflow <= 1'b1;
                    end
                    if (last_lat) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
